// File: rtl/data_player_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_player_pkg
// Brief   : Shared register map, identification constant, playback state
//           encoding and pointer-width helper for the data_player block.
// Revision: 1.0 - initial release
// ============================================================================
package data_player_pkg;

  // Word offsets of the register block, relative to BASE_ADDR
  localparam logic [2:0] REG_CONST       = 3'd0;
  localparam logic [2:0] REG_SOFT_RESETN = 3'd1;
  localparam logic [2:0] REG_CHAN        = 3'd2;
  localparam logic [2:0] REG_EN          = 3'd3;
  localparam logic [2:0] REG_DEPTH       = 3'd4;
  localparam logic [2:0] REG_TRIG_EN     = 3'd5;
  localparam logic [2:0] REG_RAM_DATA    = 3'd6;

  // Identification word returned by the CONST register
  localparam logic [31:0] DATA_PLAY_CONST = 32'hDA7A_0B1A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PLAY  = 2'd2
  } state_e;

  // Ceiling log2, never below 1, so a pointer always has at least one bit
  function automatic int log2(input int value);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) w = w + 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram.sv
`default_nettype none
// ============================================================================
// Module  : dp_ram
// Brief   : Simple dual-port synchronous RAM, one write port and one
//           registered read port. Contents are not reset.
// Revision: 1.0 - initial release
// ============================================================================
module dp_ram #(
  parameter int DATA_WIDTH = 31,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/data_player.sv
`default_nettype none
// ============================================================================
// Module  : data_player
// Brief   : Bus-loaded multi-channel pattern player. Software loads one RAM
//           per channel, sets a depth and arms; words then stream out on
//           NUM_PORTS channels, advanced by the start input.
// Revision: 1.0 - initial release
// ============================================================================
module data_player
  import data_player_pkg::*;
#(
  parameter int                        BUS_ADDR_WIDTH = 32,
  // Word address of the block: byte address 0x5210_0000 divided by 4
  parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = BUS_ADDR_WIDTH'(32'h1484_0000),
  parameter int                        NUM_PORTS      = 3,
  parameter int                        DATA_WIDTH     = 31,
  parameter int                        DATA_DEPTH     = 12369
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data,
  output logic [NUM_PORTS-1:0]            valid,
  output logic                            busy,
  input  logic [BUS_ADDR_WIDTH-1:0]       bus_addr,
  input  logic [31:0]                     bus_wdata,
  output logic [31:0]                     bus_rdata,
  input  logic                            bus_wr,
  input  logic                            bus_rd
);

  localparam int PW = log2(DATA_DEPTH);      // RAM pointer width
  localparam int DW = log2(DATA_DEPTH + 1);  // DEPTH register width
  localparam int CW = log2(NUM_PORTS);       // channel index width

  state_e                          state_q, state_d;
  logic [PW-1:0]                   play_ptr_q, play_ptr_d;
  logic [PW-1:0]                   bus_ptr_q, bus_ptr_d;
  logic [31:0]                     chan_q, chan_d;
  logic [NUM_PORTS-1:0]            en_q, en_d;
  logic [DW-1:0]                   depth_q, depth_d;
  logic                            loop_q, loop_d;
  logic                            iss_q, iss_d;
  logic [NUM_PORTS-1:0]            valid_q, valid_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_q, data_d;
  logic                            rd_p1_q, rd_p1_d;
  logic                            rd_ram_q, rd_ram_d;
  logic [CW-1:0]                   rd_chan_q, rd_chan_d;
  logic [31:0]                     rd_val_q, rd_val_d;
  logic [31:0]                     rdata_q, rdata_d;

  logic [BUS_ADDR_WIDTH-1:0] bus_off;
  logic                      bus_hit;
  logic [2:0]                reg_sel;
  logic                      chan_ok;
  logic [CW-1:0]             chan_idx;
  logic                      busy_int;
  logic                      issue;
  logic                      last_addr;
  logic [PW-1:0]             bus_ptr_inc;
  logic [PW-1:0]             ram_raddr;
  logic [NUM_PORTS-1:0]      ram_we;
  logic                      soft_rst;
  logic [DATA_WIDTH-1:0]     ram_rdata [NUM_PORTS];

  assign bus_off     = bus_addr - BASE_ADDR;
  assign bus_hit     = bus_off < BUS_ADDR_WIDTH'(7);
  assign reg_sel     = bus_off[2:0];
  assign chan_ok     = chan_q < 32'(NUM_PORTS);
  assign chan_idx    = chan_q[CW-1:0];
  // Busy covers the word still in the RAM read stage after the last issue
  assign busy_int    = (state_q != IDLE) || iss_q;
  assign issue       = ((state_q == ARMED) || (state_q == PLAY)) && start;
  assign last_addr   = (DW'(play_ptr_q) == (depth_q - DW'(1)));
  assign bus_ptr_inc = (bus_ptr_q == PW'(DATA_DEPTH - 1)) ? '0 : bus_ptr_q + PW'(1);
  // The bus owns the read port only while nothing is playing
  assign ram_raddr   = (state_q == IDLE) ? bus_ptr_q : play_ptr_q;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ram
      dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DATA_DEPTH),
        .ADDR_W     (PW)
      ) u_ram (
        .clk   (clk),
        .we    (ram_we[i]),
        .waddr (bus_ptr_q),
        .wdata (bus_wdata[DATA_WIDTH-1:0]),
        .raddr (ram_raddr),
        .rdata (ram_rdata[i])
      );
    end
  endgenerate

  // Next-state logic: playback sequencing, output stage and register bus
  always_comb begin
    state_d    = state_q;
    play_ptr_d = play_ptr_q;
    bus_ptr_d  = bus_ptr_q;
    chan_d     = chan_q;
    en_d       = en_q;
    depth_d    = depth_q;
    loop_d     = loop_q;
    iss_d      = 1'b0;
    valid_d    = '0;
    data_d     = data_q;
    rd_p1_d    = 1'b0;
    rd_ram_d   = 1'b0;
    rd_chan_d  = rd_chan_q;
    rd_val_d   = '0;
    rdata_d    = rdata_q;
    ram_we     = '0;
    soft_rst   = 1'b0;

    if (issue) begin
      iss_d = 1'b1;
      if (last_addr) begin
        play_ptr_d = '0;
        state_d    = loop_q ? PLAY : IDLE;
      end else begin
        play_ptr_d = play_ptr_q + PW'(1);
        state_d    = PLAY;
      end
    end

    // Disabled channels output 0; enabled ones hold between words
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_d[i] = iss_q & en_q[i];
      if (!en_q[i])   data_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (iss_q) data_d[i*DATA_WIDTH +: DATA_WIDTH] = ram_rdata[i];
    end

    if (rd_p1_q) rdata_d = rd_ram_q ? 32'(ram_rdata[rd_chan_q]) : rd_val_q;

    // Every read returns something two cycles later; misses return 0
    if (bus_rd) begin
      rd_p1_d = 1'b1;
      if (bus_hit) begin
        case (reg_sel)
          REG_CONST:   rd_val_d = DATA_PLAY_CONST;
          REG_CHAN:    rd_val_d = chan_q;
          REG_EN:      rd_val_d = {31'b0, chan_ok & en_q[chan_idx]};
          REG_DEPTH:   rd_val_d = 32'(depth_q);
          REG_TRIG_EN: rd_val_d = {30'b0, loop_q, busy_int};
          REG_RAM_DATA: begin
            if (!busy_int && chan_ok) begin
              rd_ram_d  = 1'b1;
              rd_chan_d = chan_idx;
              bus_ptr_d = bus_ptr_inc;
            end
          end
          default:     rd_val_d = '0;
        endcase
      end
    end

    if (bus_wr && bus_hit) begin
      case (reg_sel)
        REG_SOFT_RESETN: soft_rst = bus_wdata[0];
        REG_CHAN: begin
          chan_d    = bus_wdata;
          bus_ptr_d = '0;
        end
        REG_EN: begin
          if (chan_ok) en_d[chan_idx] = bus_wdata[0];
        end
        REG_DEPTH: begin
          if (!busy_int) begin
            if (bus_wdata > 32'(DATA_DEPTH)) depth_d = DW'(DATA_DEPTH);
            else                             depth_d = bus_wdata[DW-1:0];
          end
        end
        REG_TRIG_EN: begin
          if (bus_wdata[0]) begin
            if ((state_q == IDLE) && (depth_q != '0)) begin
              state_d    = ARMED;
              loop_d     = bus_wdata[1];
              play_ptr_d = '0;
            end
          end else begin
            // Abort: drop in-flight words, keep the held output data
            state_d    = IDLE;
            play_ptr_d = '0;
            iss_d      = 1'b0;
            valid_d    = '0;
            data_d     = data_q;
          end
        end
        REG_RAM_DATA: begin
          if (!busy_int && chan_ok) begin
            ram_we[chan_idx] = 1'b1;
            bus_ptr_d        = bus_ptr_inc;
          end
        end
        default: ;
      endcase
    end

    // Soft reset clears everything except CHAN and the RAM contents
    if (soft_rst) begin
      state_d    = IDLE;
      play_ptr_d = '0;
      bus_ptr_d  = '0;
      en_d       = '0;
      depth_d    = '0;
      loop_d     = 1'b0;
      iss_d      = 1'b0;
      valid_d    = '0;
      data_d     = '0;
      rd_p1_d    = 1'b0;
      rd_ram_d   = 1'b0;
      rd_val_d   = '0;
      rdata_d    = '0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      play_ptr_q <= '0;
      bus_ptr_q  <= '0;
      chan_q     <= '0;
      en_q       <= '0;
      depth_q    <= '0;
      loop_q     <= 1'b0;
      iss_q      <= 1'b0;
      valid_q    <= '0;
      data_q     <= '0;
      rd_p1_q    <= 1'b0;
      rd_ram_q   <= 1'b0;
      rd_chan_q  <= '0;
      rd_val_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      play_ptr_q <= play_ptr_d;
      bus_ptr_q  <= bus_ptr_d;
      chan_q     <= chan_d;
      en_q       <= en_d;
      depth_q    <= depth_d;
      loop_q     <= loop_d;
      iss_q      <= iss_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      rd_p1_q    <= rd_p1_d;
      rd_ram_q   <= rd_ram_d;
      rd_chan_q  <= rd_chan_d;
      rd_val_q   <= rd_val_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_int;
  assign bus_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_player.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_player
// Brief   : Self-checking bench for data_player with random RAM contents and
//           start patterns, compared against a cycle-level behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_player;

  localparam int          NP   = 3;
  localparam int          DWID = 31;
  localparam int          DEP  = 16;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h1484_0000;

  localparam int O_CONST = 0, O_SOFT = 1, O_CHAN = 2, O_EN = 3;
  localparam int O_DEPTH = 4, O_TRIG = 5, O_RAM = 6;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              start = 1'b0;
  logic              bus_wr = 1'b0;
  logic              bus_rd = 1'b0;
  logic [AW-1:0]     bus_addr = '0;
  logic [31:0]       bus_wdata = '0;
  logic [NP*DWID-1:0] data;
  logic [NP-1:0]     valid;
  logic              busy;
  logic [31:0]       bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [DWID-1:0] mem  [NP][DEP];
  logic [DWID-1:0] held [NP];
  logic [NP-1:0]   en_m;
  logic [31:0]     rv;

  always #5 clk = ~clk;

  data_player #(
    .BUS_ADDR_WIDTH (AW),
    .BASE_ADDR      (BASE),
    .NUM_PORTS      (NP),
    .DATA_WIDTH     (DWID),
    .DATA_DEPTH     (DEP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .data      (data),
    .valid     (valid),
    .busy      (busy),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int off, input logic [31:0] v);
    bus_addr  = BASE + 32'(off);
    bus_wdata = v;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input int off, output logic [31:0] v);
    bus_addr = BASE + 32'(off);
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
    tick();
    v = bus_rdata;
  endtask

  task automatic set_en(input int ch, input bit v);
    bus_write(O_CHAN, 32'(ch));
    bus_write(O_EN, {31'b0, v});
    en_m[ch] = v;
  endtask

  // Plays n cycles from ARMED and checks valid/data/busy every cycle.
  // Optionally a bus write (abort or soft reset) is issued at cycle abort_at.
  task automatic run_play(input string tag, input int n, input int depth, input bit lp,
                          input bit rnd, input int abort_at, input int abort_off,
                          input logic [31:0] abort_val);
    bit pat[];
    bit ev[];
    int ew[];
    bit act[];
    int addr;
    bit active;
    logic [NP-1:0]      exp_v;
    logic [NP*DWID-1:0] exp_d;
    pat = new[n];
    ev  = new[n + 3];
    ew  = new[n + 3];
    act = new[n + 3];
    addr = 0;
    active = 1'b1;
    for (int c = 0; c < n; c++) begin
      act[c] = active;
      if (!rnd)      pat[c] = 1'b1;
      else if (c < 5) pat[c] = (c != 1) && (c != 4);
      else           pat[c] = 1'($urandom_range(0, 1));
      if (active && pat[c]) begin
        ev[c + 2] = 1'b1;
        ew[c + 2] = addr;
        addr++;
        if (addr == depth) begin
          addr = 0;
          if (!lp) active = 1'b0;
        end
      end
    end
    for (int c = n; c < n + 3; c++) act[c] = active;
    if (abort_at >= 0) begin
      for (int k = abort_at + 1; k < n + 3; k++) begin
        ev[k]  = 1'b0;
        act[k] = 1'b0;
      end
    end
    for (int i = 0; i < NP; i++) if (!en_m[i]) held[i] = '0;

    for (int c = 0; c < n + 2; c++) begin
      start = (c < n) ? pat[c] : 1'b0;
      if (c == abort_at) begin
        bus_addr  = BASE + 32'(abort_off);
        bus_wdata = abort_val;
        bus_wr    = 1'b1;
      end else begin
        bus_wr    = 1'b0;
      end
      if (abort_off == O_SOFT && abort_at >= 0 && c == abort_at + 1)
        for (int i = 0; i < NP; i++) held[i] = '0;
      exp_v = ev[c] ? en_m : '0;
      for (int i = 0; i < NP; i++) begin
        if (en_m[i] && ev[c]) held[i] = mem[i][ew[c]];
        exp_d[i*DWID +: DWID] = en_m[i] ? held[i] : '0;
      end
      check($sformatf("%s_valid_c%0d", tag, c), 128'(valid), 128'(exp_v));
      check($sformatf("%s_data_c%0d", tag, c), 128'(data), 128'(exp_d));
      if (act[c])
        check($sformatf("%s_busy_c%0d", tag, c), 128'(busy), 128'(1));
      else if (!ev[c] && !ev[c + 1])
        check($sformatf("%s_idle_c%0d", tag, c), 128'(busy), 128'(0));
      tick();
    end
    bus_wr = 1'b0;
    start  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    en_m = '0;
    for (int i = 0; i < NP; i++) held[i] = '0;

    // Reset and identification
    #2 resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(valid), 128'(0));
    check("rst_data", 128'(data), 128'(0));
    check("rst_rdata", 128'(bus_rdata), 128'(0));
    bus_read(O_CONST, rv);
    check("const", 128'(rv), 128'(32'hDA7A_0B1A));
    bus_read(O_TRIG, rv);
    check("trig_rst", 128'(rv), 128'(0));
    bus_read(7, rv);
    check("miss_read", 128'(rv), 128'(0));

    // Load channel 1 with one word more than the depth: pointer wraps
    bus_write(O_CHAN, 32'd1);
    for (int i = 0; i < DEP + 1; i++) begin
      w = $urandom();
      bus_write(O_RAM, w);
      mem[1][i % DEP] = w[DWID-1:0];
    end
    bus_write(O_CHAN, 32'd1);
    for (int i = 0; i < DEP; i++) begin
      bus_read(O_RAM, rv);
      check($sformatf("wrap_rb%0d", i), 128'(rv), 128'({1'b0, mem[1][i]}));
    end
    bus_write(O_CHAN, 32'd5);
    bus_write(O_RAM, 32'h1234_5678);
    bus_read(O_RAM, rv);
    check("chan5_ram", 128'(rv), 128'(0));
    bus_read(O_CHAN, rv);
    check("chan5_rb", 128'(rv), 128'(5));
    bus_write(O_CHAN, 32'd1);
    bus_read(O_RAM, rv);
    check("chan5_noeffect", 128'(rv), 128'({1'b0, mem[1][0]}));

    // Load all channels and enable them
    for (int ch = 0; ch < NP; ch++) begin
      bus_write(O_CHAN, 32'(ch));
      for (int i = 0; i < DEP; i++) begin
        w = $urandom();
        bus_write(O_RAM, w);
        mem[ch][i] = w[DWID-1:0];
      end
    end
    for (int ch = 0; ch < NP; ch++) set_en(ch, 1'b1);
    bus_read(O_EN, rv);
    check("en_rb", 128'(rv), 128'(1));

    // Basic play, continuous start
    bus_write(O_DEPTH, 32'd8);
    bus_read(O_DEPTH, rv);
    check("depth_rb", 128'(rv), 128'(8));
    bus_write(O_TRIG, 32'd1);
    run_play("play", 12, 8, 1'b0, 1'b0, -1, 0, 32'd0);

    // Stalled play with a random start pattern
    bus_write(O_TRIG, 32'd1);
    run_play("stall", 40, 8, 1'b0, 1'b1, -1, 0, 32'd0);
    bus_write(O_TRIG, 32'd0);

    // Looping with channel 1 disabled, then abort with words in flight
    set_en(1, 1'b0);
    bus_write(O_DEPTH, 32'd4);
    bus_write(O_TRIG, 32'd3);
    bus_read(O_TRIG, rv);
    check("trig_armed", 128'(rv), 128'(3));
    bus_write(O_DEPTH, 32'd2);
    bus_read(O_DEPTH, rv);
    check("depth_busy_ignored", 128'(rv), 128'(4));
    run_play("loop", 14, 4, 1'b1, 1'b0, 11, O_TRIG, 32'd0);
    bus_read(O_TRIG, rv);
    check("trig_aborted", 128'(rv), 128'(2));

    // Soft reset in the middle of a play
    set_en(1, 1'b1);
    bus_write(O_DEPTH, 32'd8);
    bus_write(O_TRIG, 32'd1);
    run_play("soft", 8, 8, 1'b0, 1'b0, 3, O_SOFT, 32'd1);
    en_m = '0;
    bus_read(O_CONST, rv);
    check("soft_const", 128'(rv), 128'(32'hDA7A_0B1A));
    bus_read(O_DEPTH, rv);
    check("soft_depth", 128'(rv), 128'(0));
    bus_read(O_TRIG, rv);
    check("soft_trig", 128'(rv), 128'(0));
    bus_read(O_EN, rv);
    check("soft_en", 128'(rv), 128'(0));
    for (int ch = 0; ch < NP; ch++) begin
      bus_write(O_CHAN, 32'(ch));
      for (int i = 0; i < DEP; i++) begin
        bus_read(O_RAM, rv);
        check($sformatf("soft_rb%0d_%0d", ch, i), 128'(rv), 128'({1'b0, mem[ch][i]}));
      end
    end

    // Asynchronous reset in the middle of a play
    set_en(0, 1'b1);
    bus_write(O_DEPTH, 32'd8);
    bus_write(O_TRIG, 32'd1);
    start = 1'b1;
    repeat (4) tick();
    check("pre_reset_valid", 128'(valid), 128'(1));
    resetn = 1'b0;
    #1;
    check("areset_valid", 128'(valid), 128'(0));
    check("areset_data", 128'(data), 128'(0));
    check("areset_busy", 128'(busy), 128'(0));
    check("areset_rdata", 128'(bus_rdata), 128'(0));
    start = 1'b0;
    tick();
    resetn = 1'b1;
    en_m = '0;
    for (int i = 0; i < NP; i++) held[i] = '0;
    tick();

    // Arm refusal with zero depth, and depth clamping
    bus_write(O_TRIG, 32'd1);
    check("refuse_busy", 128'(busy), 128'(0));
    bus_read(O_TRIG, rv);
    check("refuse_trig", 128'(rv), 128'(0));
    bus_write(O_DEPTH, 32'd20000);
    bus_read(O_DEPTH, rv);
    check("depth_clamp", 128'(rv), 128'(DEP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
